bar_graph_renderer: RTL and testbench
=====================================

Name: bar_graph_renderer

Overview:
- Pixel generator directly downstream of the VGA timing counter (800x521 frame, 25 MHz pixel clock).
- Consumes hcs, vcs, hsync, vsync and activevideo. Produces 12-bit RGB plus sync signals delayed to match the RGB.
- Draws NUM_BARS vertical bars, one per power-quality metric.
- Bar heights arrive through a valid/ready write port into a shadow bank. The shadow bank is committed to the display bank only at frame start, so a frame never tears.

Parameters:
- NUM_BARS, 8, number of bars (power of 2, at most 16).
- BAR_W, 80, bar width in pixels (NUM_BARS*BAR_W = 640).
- HEIGHT_W, 9, height field width; the full-scale value is 480.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcs  in  10  horizontal count, 0..799
- vcs  in  10  vertical count, 0..520
- hsync  in  1  horizontal sync from the timing block
- vsync  in  1  vertical sync from the timing block
- activevideo  in  1  visible-region flag
- upd_valid  in  1  height update request
- upd_ready  out  1  update accepted when both upd_valid and upd_ready are high
- upd_idx  in  4  bar index
- upd_height  in  HEIGHT_W  new bar height in pixels
- bad_idx  out  1  one-cycle pulse when an accepted update has upd_idx >= NUM_BARS
- hsync_o  out  1  hsync delayed 2 cycles
- vsync_o  out  1  vsync delayed 2 cycles
- red  out  4  red channel
- green  out  4  green channel
- blue  out  4  blue channel

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both height banks are cleared to 0 and the dirty flag is cleared.
  - All pipeline registers are cleared, so hsync_o, vsync_o, red, green, blue and bad_idx are 0.
  - Reset mid-frame blanks the output immediately. Rendering resumes at the next pixel after rst_n rises.
- Visible coordinates: x = hcs-144, y = vcs-30. A pixel is visible when activevideo=1, x is 0..639 and y is 0..479. Column hcs=143 is treated as not visible, which forces black on that column.
- Update port:
  - upd_ready = 0 only on the commit cycle (hcs==0 and vcs==0); it is 1 on every other cycle.
  - On an accepted update, the shadow bank entry [upd_idx] is written with min(upd_height, 480) and dirty is set.
  - If upd_idx >= NUM_BARS, the update is still accepted but the data is discarded, and bad_idx pulses in the next cycle.
  - Back-to-back updates are allowed, one per cycle. If the same index is written twice, the last write wins.
- Commit: on the commit cycle, if dirty = 1, the whole shadow bank is copied to the display bank and dirty is cleared. A write presented on the commit cycle is held off by upd_ready = 0 and lands in the next frame.
- Pipeline (latency 2):
  - Stage 1 registers the visible flag, y, hsync and vsync. It also maintains a bar-index counter and an in-bar column counter, both reset when x = 0. The bar index increments when the column counter reaches BAR_W-1. No divider is used.
  - Stage 2 compares (479 - y) < display_height[bar_idx]. On a hit it outputs PALETTE[bar_idx]; otherwise it outputs background 0x000.
  - Non-visible pixels output 0x000.
  - hsync_o and vsync_o are hsync and vsync delayed exactly 2 cycles.
- Boundaries:
  - Height 0 draws nothing.
  - Height 480 fills the whole column range from y = 0 to 479.
  - The bar counter never exceeds NUM_BARS-1 within a line.

Optional Feature:
- Macro: BAR_GRID_EN.
- When defined:
  - Stage 2 paints gridline colour 0x444 on rows where y mod 60 == 0 and no bar is hit. A row counter resets at y = 0 and wraps at 59.
  - The last column of each bar (column counter == BAR_W-1) is forced to 0x000 to give a 1-pixel gap.
- When not defined: no row counter, no gridlines, no gap. Latency is 2 in both builds.

Decomposition:
- Package pq_vga_pkg holds:
  - The timing constants: H_ACTIVE_START 144, V_ACTIVE_START 30, ACTIVE_W 640, ACTIVE_H 480, FULL_SCALE 480.
  - The 12-bit PALETTE array, indexed by bar, and GRID_COLOR.
  - A height_t typedef.
- Sub-module bar_height_bank: the shadow bank, display bank, dirty flag, commit logic and update handshake, with one asynchronous read port indexed by bar_idx.

Test Plan:
- Reset, no updates, run a full frame -> RGB = 0 everywhere. hsync_o and vsync_o equal the inputs shifted 2 cycles.
- Write bar 0 = 480 and bar 3 = 240 mid-frame -> no change in the current frame. Next frame: x 0..79 coloured for all y; bar 3 coloured only for y 240..479.
- upd_valid held high at hcs=0, vcs=0 -> upd_ready = 0 for that cycle. The write is accepted on the next cycle and displayed in the following frame.
- upd_idx = 9 -> bad_idx pulses once and all displayed heights are unchanged.
- upd_height = 511 -> clamped; the bar is drawn identically to height 480.
- With BAR_GRID_EN: all heights 0 -> rows y = 0, 60, ..., 420 are 0x444; columns x = 79, 159, ... are 0x000.

Source files
------------

// File: rtl/pq_vga_pkg.sv
// Shared constants and types for the bar-graph renderer: timing origin, active area, colours.
package pq_vga_pkg;

    localparam int H_ACTIVE_START = 144;
    localparam int V_ACTIVE_START = 30;
    localparam int ACTIVE_W       = 640;
    localparam int ACTIVE_H       = 480;
    localparam int FULL_SCALE     = 480;
    localparam int GRID_ROWS      = 60;
    localparam int HEIGHT_BITS    = 9;

    typedef logic [HEIGHT_BITS-1:0] height_t;
    typedef logic [11:0]            rgb_t;

    localparam rgb_t BG_COLOR   = 12'h000;
    localparam rgb_t GRID_COLOR = 12'h444;

    localparam rgb_t PALETTE [16] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80, 12'h8F0,
        12'h08F, 12'hF08, 12'h80F, 12'h0F8, 12'hFFF, 12'h888, 12'hA52, 12'h5A2
    };

endpackage

// File: rtl/bar_graph_renderer_if.sv
// Height-update port of the bar-graph renderer.
interface bar_graph_renderer_if #(
    parameter int HEIGHT_W = 9
);
    // An update transfers on a cycle where upd_valid && upd_ready; the master holds
    // upd_valid, upd_idx and upd_height stable until that cycle.
    logic                upd_valid;
    logic                upd_ready;
    logic [3:0]          upd_idx;
    logic [HEIGHT_W-1:0] upd_height;
    logic                bad_idx;

    modport master (output upd_valid, upd_idx, upd_height, input upd_ready, bad_idx);
    modport slave  (input upd_valid, upd_idx, upd_height, output upd_ready, bad_idx);

endinterface

// File: rtl/bar_height_bank.sv
// Double-buffered bar heights: writes land in the shadow bank, which is copied to the
// display bank on the frame-start commit cycle only when something changed.
module bar_height_bank
    import pq_vga_pkg::*;
#(
    parameter int NUM_BARS = 8,
    parameter int HEIGHT_W = 9,
    parameter int IDX_W    = $clog2(NUM_BARS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit_i,
    bar_graph_renderer_if.slave  upd,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output height_t              rd_height_o
);

    height_t shadow_q [NUM_BARS];
    height_t disp_q   [NUM_BARS];
    logic    dirty_q;
    logic    bad_q;
    logic    accept;
    logic    idx_ok;
    height_t wr_height;

    assign upd.upd_ready = !commit_i;
    assign upd.bad_idx   = bad_q;
    assign accept        = upd.upd_valid && !commit_i;
    assign idx_ok        = {1'b0, upd.upd_idx} < 5'(NUM_BARS);
    assign wr_height     = (upd.upd_height > HEIGHT_W'(FULL_SCALE)) ? height_t'(FULL_SCALE)
                                                                     : height_t'(upd.upd_height);
    assign rd_height_o   = disp_q[rd_idx_i];

    // Writes are blocked on the commit cycle, so copy and write never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
            dirty_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            bad_q <= accept && !idx_ok;
            if (commit_i && dirty_q) begin
                for (int i = 0; i < NUM_BARS; i++) disp_q[i] <= shadow_q[i];
                dirty_q <= 1'b0;
            end
            if (accept && idx_ok) begin
                shadow_q[upd.upd_idx[IDX_W-1:0]] <= wr_height;
                dirty_q                          <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bar_graph_renderer.sv
// Bar-graph pixel generator, two-cycle latency from timing inputs to RGB/sync outputs.
// Define BAR_GRID_EN for gridlines every 60 rows and a 1-pixel gap after each bar.
module bar_graph_renderer
    import pq_vga_pkg::*;
#(
    parameter int NUM_BARS = 8,
    parameter int BAR_W    = 80,
    parameter int HEIGHT_W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          hcs,
    input  logic [9:0]          vcs,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                activevideo,
    bar_graph_renderer_if.slave upd,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue
);

    localparam int IDX_W = $clog2(NUM_BARS);
    localparam int COL_W = $clog2(BAR_W);

    logic             commit, line_start;
    logic             vis_d, vis_q;
    logic [9:0]       y_d, y_q;
    logic             hs1_q, vs1_q, hs2_q, vs2_q;
    logic [IDX_W-1:0] bar_d, bar_q;
    logic [COL_W-1:0] col_d, col_q;
    height_t          bar_height;
    logic [9:0]       inv_y;
    logic             hit;
    rgb_t             rgb_d, rgb_q;

    assign commit     = (hcs == 10'd0) && (vcs == 10'd0);
    assign line_start = (hcs == 10'(H_ACTIVE_START));
    // hcs=143 falls outside this window even when activevideo is already high.
    assign vis_d = activevideo
                && (hcs >= 10'(H_ACTIVE_START)) && (hcs < 10'(H_ACTIVE_START + ACTIVE_W))
                && (vcs >= 10'(V_ACTIVE_START)) && (vcs < 10'(V_ACTIVE_START + ACTIVE_H));
    assign y_d   = vcs - 10'(V_ACTIVE_START);

    // Bar index tracks x without a divider; it saturates at the last bar.
    always_comb begin
        bar_d = bar_q;
        col_d = col_q + 1'b1;
        if (line_start) begin
            bar_d = '0;
            col_d = '0;
        end else if (col_q == COL_W'(BAR_W - 1)) begin
            col_d = '0;
            if (bar_q != IDX_W'(NUM_BARS - 1)) bar_d = bar_q + 1'b1;
        end
    end

`ifdef BAR_GRID_EN
    logic [5:0] row_d, row_q;

    always_comb begin
        row_d = row_q;
        if (line_start) begin
            if ((vcs == 10'(V_ACTIVE_START)) || (row_q == 6'(GRID_ROWS - 1))) row_d = '0;
            else row_d = row_q + 6'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis_q <= 1'b0;
            y_q   <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            bar_q <= '0;
            col_q <= '0;
`ifdef BAR_GRID_EN
            row_q <= '0;
`endif
        end else begin
            vis_q <= vis_d;
            y_q   <= y_d;
            hs1_q <= hsync;
            vs1_q <= vsync;
            bar_q <= bar_d;
            col_q <= col_d;
`ifdef BAR_GRID_EN
            row_q <= row_d;
`endif
        end
    end

    bar_height_bank #(
        .NUM_BARS (NUM_BARS),
        .HEIGHT_W (HEIGHT_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_i    (commit),
        .upd         (upd),
        .rd_idx_i    (bar_q),
        .rd_height_o (bar_height)
    );

    // Bars grow upward from y=479: pixel is lit when its distance from the bottom is below the height.
    assign inv_y = 10'(ACTIVE_H - 1) - y_q;
    assign hit   = vis_q && ({1'b0, bar_height} > inv_y);

    always_comb begin
        rgb_d = BG_COLOR;
        if (hit) rgb_d = PALETTE[4'(bar_q)];
`ifdef BAR_GRID_EN
        else if (vis_q && (row_q == 6'd0)) rgb_d = GRID_COLOR;
        if (vis_q && (col_q == COL_W'(BAR_W - 1))) rgb_d = BG_COLOR;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;
    assign red     = rgb_q[11:8];
    assign green   = rgb_q[7:4];
    assign blue    = rgb_q[3:0];

endmodule

// File: tb/tb_bar_graph_renderer.sv
// Bench for bar_graph_renderer: compressed frames, directed and random height updates,
// checked every cycle against a frame-level model of the bars.
module tb_bar_graph_renderer;

    localparam int NB = 8;
    localparam int BW = 80;
    localparam int HW = 9;
    localparam int FIXED_Y [7] = '{0, 60, 239, 240, 379, 380, 479};
    localparam int SHORT_H [5] = '{0, 1, 143, 144, 145};
    localparam logic [11:0] TB_PAL [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                           12'h0FF, 12'hF0F, 12'hF80, 12'h8F0};
`ifdef BAR_GRID_EN
    localparam logic [11:0] Y0_BG = 12'h444;
`else
    localparam logic [11:0] Y0_BG = 12'h000;
`endif

    typedef struct {
        int idx;
        int h;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcs = '0;
    logic [9:0] vcs = '0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       activevideo = 1'b0;
    logic       hsync_o, vsync_o;
    logic [3:0] red, green, blue;

    bar_graph_renderer_if #(.HEIGHT_W(HW)) upd_bus ();

    bar_graph_renderer #(.NUM_BARS(NB), .BAR_W(BW), .HEIGHT_W(HW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcs         (hcs),
        .vcs         (vcs),
        .hsync       (hsync),
        .vsync       (vsync),
        .activevideo (activevideo),
        .upd         (upd_bus),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    // clock / reset
    always #20 clk = ~clk;

    // model state
    int          shadow [NB];
    int          disp   [NB];
    bit          dirty;
    int          frame;
    bit          rand_en;
    req_t        req_q [$];
    logic [13:0] exp_q [$];
    int          meta_q [$];
    logic        exp_bad_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            shadow[i] = 0;
            disp[i]   = 0;
        end
        dirty = 0;
        req_q.delete();
        exp_q.delete();
        meta_q.delete();
        exp_bad_q.delete();
    endtask

    // driver: one pixel per call, model updated from the spec rules
    task automatic pix(input int h, input int v);
        int x, y, b;
        bit vis, rdy, bad;
        logic [11:0] rgb;
        req_t r;
        @(negedge clk);
        if (rand_en && $urandom_range(0, 39) == 0) begin
            r.idx = $urandom_range(0, 15);
            r.h   = ($urandom_range(0, 4) == 0) ? 480 + $urandom_range(0, 31) : $urandom_range(0, 479);
            req_q.push_back(r);
        end
        hcs         = 10'(h);
        vcs         = 10'(v);
        hsync       = (h >= 96);
        vsync       = (v >= 2);
        activevideo = (h >= 143) && (h < 784) && (v >= 30) && (v < 510);
        if (req_q.size() > 0) begin
            upd_bus.upd_valid  = 1'b1;
            upd_bus.upd_idx    = 4'(req_q[0].idx);
            upd_bus.upd_height = 9'(req_q[0].h);
        end else begin
            upd_bus.upd_valid  = 1'b0;
            upd_bus.upd_idx    = 4'($urandom_range(0, 15));
            upd_bus.upd_height = 9'($urandom_range(0, 511));
        end
        rdy = !(h == 0 && v == 0);
        #1;
        check("upd_ready", v * 1000 + h, 32'(upd_bus.upd_ready), 32'(rdy));

        x = h - 144;
        y = v - 30;
        vis = activevideo && x >= 0 && x < 640 && y >= 0 && y < 480;
        rgb = 12'h000;
        if (vis) begin
            b = x / BW;
            if ((479 - y) < disp[b]) rgb = TB_PAL[b];
`ifdef BAR_GRID_EN
            else if (y % 60 == 0) rgb = 12'h444;
            if (x % BW == BW - 1) rgb = 12'h000;
`endif
        end
        exp_q.push_back({hsync, vsync, rgb});
        meta_q.push_back(frame * 1000000 + v * 1000 + h);

        bad = 0;
        if (!rdy && dirty) begin
            for (int i = 0; i < NB; i++) disp[i] = shadow[i];
            dirty = 0;
        end
        if (upd_bus.upd_valid && rdy) begin
            r = req_q.pop_front();
            if (r.idx < NB) begin
                shadow[r.idx] = (r.h > 480) ? 480 : r.h;
                dirty = 1;
            end else begin
                bad = 1;
            end
        end
        exp_bad_q.push_back(bad);
    endtask

    // hand-computed pixels that pin the model
    task automatic pin(input int m, input logic [11:0] act);
        int f, v, h;
        f = m / 1000000;
        v = (m / 1000) % 1000;
        h = m % 1000;
        if (f == 0 && v == 30  && h == 184) check("pin_f0_empty",     m, 32'(act), 32'(Y0_BG));
        if (f == 1 && v == 30  && h == 184) check("pin_f1_bar0_top",  m, 32'(act), 32'h0F00);
        if (f == 1 && v == 269 && h == 394) check("pin_f1_bar3_y239", m, 32'(act), 32'h0000);
        if (f == 1 && v == 270 && h == 394) check("pin_f1_bar3_y240", m, 32'(act), 32'h0FF0);
        if (f == 1 && v == 509 && h == 394) check("pin_f1_bar3_y479", m, 32'(act), 32'h0FF0);
        if (f == 1 && v == 270 && h == 143) check("pin_f1_col143",    m, 32'(act), 32'h0000);
        if (f == 1 && v == 509 && h == 549) check("pin_f1_bar5_held", m, 32'(act), 32'h0000);
        if (f == 2 && v == 509 && h == 549) check("pin_f2_bar5_y479", m, 32'(act), 32'h0F0F);
        if (f == 2 && v == 409 && h == 549) check("pin_f2_bar5_y379", m, 32'(act), 32'h0000);
        if (f == 2 && v == 410 && h == 549) check("pin_f2_bar5_y380", m, 32'(act), 32'h0F0F);
        if (f == 3 && v == 30  && h == 629) check("pin_f3_bar6_clamp", m, 32'(act), 32'h0F80);
        if (f == 3 && v == 30  && h == 783) check("pin_f3_bar7_empty", m, 32'(act), 32'h0000);
    endtask

    // scoreboard: outputs after edge k reflect the pixel driven two edges earlier
    always @(posedge clk) begin
        logic [13:0] e;
        logic        eb;
        int          m;
        #1;
        if (rst_n) begin
            if (exp_bad_q.size() > 0) begin
                eb = exp_bad_q.pop_front();
                check("bad_idx", frame, 32'(upd_bus.bad_idx), 32'(eb));
            end
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                m = meta_q.pop_front();
                check("pixel", m, 32'({hsync_o, vsync_o, red, green, blue}), 32'(e));
                pin(m, {red, green, blue});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("reset_out", frame, 32'({hsync_o, vsync_o, red, green, blue, upd_bus.bad_idx}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic hook(input int f, input int v);
        req_t r;
        if (f == 0 && v == 100) begin
            r.idx = 0; r.h = 480; req_q.push_back(r);
            r.idx = 3; r.h = 240; req_q.push_back(r);
        end
        if (f == 1 && v == 0) begin
            r.idx = 5; r.h = 100; req_q.push_back(r);
        end
        if (f == 2 && v == 100) begin
            r.idx = 9; r.h = 77;  req_q.push_back(r);
            r.idx = 6; r.h = 511; req_q.push_back(r);
        end
        if (f == 4 && v == 5) do_reset();
    endtask

    initial begin
        int r1, r2;
        bit full;
        model_clear();
        frame   = 0;
        rand_en = 0;
        upd_bus.upd_valid  = 1'b0;
        upd_bus.upd_idx    = '0;
        upd_bus.upd_height = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 0, 32'({hsync_o, vsync_o, red, green, blue, upd_bus.bad_idx}), 32'h0);
        check("reset_commit_ready", 0, 32'(upd_bus.upd_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 6; f++) begin
            frame   = f;
            rand_en = (f >= 3);
            r1 = $urandom_range(0, 479);
            r2 = $urandom_range(0, 479);
            for (int v = 0; v < 521; v++) begin
                hook(f, v);
                full = 0;
                if (v >= 30 && v < 510) begin
                    foreach (FIXED_Y[i]) if (v - 30 == FIXED_Y[i]) full = 1;
                    if (v - 30 == r1 || v - 30 == r2) full = 1;
                end
                if (full) begin
                    for (int h = 0; h < 800; h++) pix(h, v);
                end else begin
                    foreach (SHORT_H[i]) pix(SHORT_H[i], v);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
